// File: rtl/sopc_compteur_cpu_debug_pkg.sv
// Shared definitions for the debug monitor RAM: engine states, default
// geometry and the bit positions of the fields inside the JTAG command word.
package sopc_compteur_cpu_debug_pkg;

    localparam int ADDR_W_DEF        = 8;
    localparam int DATA_W            = 32;
    localparam int JDO_W             = 38;

    localparam int JDO_CLR_ERR       = 35;
    localparam int JDO_RD_AFTER_LOAD = 34;
    localparam int JDO_ADDR_MSB      = 33;
    localparam int JDO_ADDR_LSB      = 26;
    localparam int JDO_WDATA_MSB     = 34;
    localparam int JDO_WDATA_LSB     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DBG_RD = 2'd1,
        ST_DBG_WR = 2'd2,
        ST_CPU_RD = 2'd3
    } mon_state_e;

endpackage

// File: rtl/sopc_compteur_cpu_debug_mon_ram_sp.sv
// Single-port RAM with a registered read port: the word at addr_i appears on
// q_o one clock after it is presented. Contents are not affected by reset.
module sopc_compteur_cpu_debug_mon_ram_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] q_q;

    // Storage write and registered read of the same port address
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        q_q <= mem_q[addr_i];
    end

    assign q_o = q_q;

endmodule

// File: rtl/sopc_compteur_cpu_debug_mon_ram.sv
// Debug monitor RAM shared between a JTAG debug engine and a CPU Avalon-MM
// slave; debug requests take priority and only the idle engine accepts work.
module sopc_compteur_cpu_debug_mon_ram
    import sopc_compteur_cpu_debug_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest
);

    mon_state_e        state_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic [DATA_W-1:0] mon_d_q;
    logic              ready_q;
    logic              error_q;
    logic              inc_q;

    logic              idle_s;
    logic              dbg_any_s;
    logic              acc_a_s;
    logic              acc_b_s;
    logic              acc_n_s;
    logic              cpu_wr_s;
    logic              cpu_rd_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_q_s;
    logic [ADDR_W-1:0] jdo_addr_s;
    logic [DATA_W-1:0] jdo_wdata_s;
    logic              unused_jdo_s;

    assign jdo_addr_s   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata_s  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign unused_jdo_s = ^{jdo[JDO_W-1:JDO_CLR_ERR+1], jdo[JDO_WDATA_LSB-1:0]};

    // Among simultaneous debug pulses, ocimem_a wins, then ocimem_b
    assign idle_s    = (state_q == ST_IDLE);
    assign dbg_any_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign acc_a_s   = idle_s & take_action_ocimem_a;
    assign acc_b_s   = idle_s & ~take_action_ocimem_a & take_action_ocimem_b;
    assign acc_n_s   = idle_s & ~take_action_ocimem_a & ~take_action_ocimem_b
                       & take_no_action_ocimem_a;
    assign cpu_wr_s  = idle_s & ~dbg_any_s & avs_write;
    assign cpu_rd_s  = idle_s & ~dbg_any_s & avs_read & ~avs_write;

    // RAM port steering: single port, so the accepted request owns it
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = mon_a_q;
        ram_wdata_s = jdo_wdata_s;
        if (acc_a_s) begin
            ram_addr_s = jdo_addr_s;
        end else if (acc_b_s) begin
            ram_we_s = 1'b1;
        end else if (cpu_wr_s) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = avs_address;
            ram_wdata_s = avs_writedata;
        end else if (cpu_rd_s) begin
            ram_addr_s = avs_address;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    sopc_compteur_cpu_debug_mon_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .q_o     (ram_q_s)
    );

    // Debug/CPU arbitration engine with its registered monitor outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_a_s) begin
                        mon_a_q <= jdo_addr_s;
                        if (jdo[JDO_CLR_ERR]) begin
                            error_q <= 1'b0;
                        end
                        // A load without read still completes in one cycle but keeps the address
                        inc_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= jdo[JDO_RD_AFTER_LOAD] ? ST_DBG_RD : ST_DBG_WR;
                    end else if (acc_b_s) begin
                        inc_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ST_DBG_WR;
                    end else if (acc_n_s) begin
                        ready_q <= 1'b0;
                        state_q <= ST_DBG_RD;
                    end else if (cpu_rd_s) begin
                        state_q <= ST_CPU_RD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DBG_RD: begin
                    mon_d_q <= ram_q_s;
                    mon_a_q <= mon_a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    ready_q <= 1'b1;
                    if (dbg_any_s) begin
                        error_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                ST_DBG_WR: begin
                    if (inc_q) begin
                        mon_a_q <= mon_a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    ready_q <= 1'b1;
                    if (dbg_any_s) begin
                        error_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                ST_CPU_RD: begin
                    if (dbg_any_s) begin
                        error_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign MonDReg         = mon_d_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;
    assign avs_readdata    = (state_q == ST_CPU_RD) ? ram_q_s : 32'h0000_0000;
    assign avs_waitrequest = (avs_read | avs_write) & ~(cpu_wr_s | (state_q == ST_CPU_RD));

endmodule

// File: tb/tb_sopc_compteur_cpu_debug_mon_ram.sv
// Self-checking bench: directed scenarios plus random debug/CPU traffic
// checked against a transaction-level model of the monitor RAM.
module tb_sopc_compteur_cpu_debug_mon_ram;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = 38'h0;
    logic        take_a = 1'b0;
    logic        take_b = 1'b0;
    logic        take_n = 1'b0;
    logic [31:0] mon_d;
    logic        mon_ready;
    logic        mon_error;
    logic [7:0]  avs_address = 8'h00;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'h0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_mem [256];
    logic [7:0]  m_a = 8'h00;
    logic [31:0] m_d = 32'h0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    sopc_compteur_cpu_debug_mon_ram #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [37:0] j_a(input logic clr, input logic rd, input logic [7:0] a);
        return {2'b00, clr, rd, a, 26'h0};
    endfunction

    function automatic logic [37:0] j_b(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    // One debug operation (0=load/opt read, 1=write, 2=stream read); starts and ends at negedge
    task automatic dbg(input int kind, input logic [37:0] j);
        jdo = j;
        case (kind)
            0: take_a = 1'b1;
            1: take_b = 1'b1;
            default: take_n = 1'b1;
        endcase
        @(posedge clk); #1;
        take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
        case (kind)
            0: begin
                m_a = j[33:26];
                if (j[35]) m_err = 1'b0;
                if (j[34]) begin m_d = m_mem[m_a]; m_a = m_a + 8'd1; end
            end
            1: begin m_mem[m_a] = j[34:3]; m_a = m_a + 8'd1; end
            default: begin m_d = m_mem[m_a]; m_a = m_a + 8'd1; end
        endcase
        @(negedge clk);
        chk("ready_low", {31'h0, mon_ready}, 32'h0);
        @(negedge clk);
        chk("ready_high", {31'h0, mon_ready}, 32'h1);
        chk("mondreg", mon_d, m_d);
        chk("monareg", {24'h0, dut.mon_a_q}, {24'h0, m_a});
        chk("error", {31'h0, mon_error}, {31'h0, m_err});
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        #1;
        chk("wr_wait", {31'h0, avs_waitrequest}, 32'h0);
        m_mem[a] = d;
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [7:0] a);
        int n;
        avs_address = a; avs_read = 1'b1;
        #1;
        n = 0;
        while (avs_waitrequest && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("rd_latency", n, 1);
        chk("rd_data", avs_readdata, m_mem[a]);
        @(posedge clk); #1;
        avs_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_mondreg", mon_d, 32'h0);
        chk("rst_ready", {31'h0, mon_ready}, 32'h1);
        chk("rst_error", {31'h0, mon_error}, 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_monareg", {24'h0, dut.mon_a_q}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) cpu_wr(i[7:0], $urandom);

        // Load 0x10 then three sequential writes
        dbg(0, j_a(1'b0, 1'b0, 8'h10));
        dbg(1, j_b(32'h1111_1111));
        dbg(1, j_b(32'h2222_2222));
        dbg(1, j_b(32'h3333_3333));
        chk("monareg_0x13", {24'h0, dut.mon_a_q}, 32'h13);
        cpu_rd(8'h10); cpu_rd(8'h11); cpu_rd(8'h12);

        dbg(0, j_a(1'b0, 1'b1, 8'h10));
        chk("rd_0x10", mon_d, 32'h1111_1111);
        dbg(2, 38'h0);
        chk("rd_0x11", mon_d, 32'h2222_2222);

        // Address wrap at the top of the RAM
        dbg(0, j_a(1'b0, 1'b0, 8'hFF));
        dbg(1, j_b(32'hCAFE_F00D));
        chk("wrap_after_wr", {24'h0, dut.mon_a_q}, 32'h0);
        dbg(0, j_a(1'b0, 1'b1, 8'hFF));
        chk("wrap_rd", mon_d, 32'hCAFE_F00D);
        dbg(2, 38'h0);

        // Back-to-back pulses: the second is dropped and flagged
        w = $urandom;
        jdo = j_b(w); take_b = 1'b1;
        @(posedge clk); #1;
        take_b = 1'b0; take_n = 1'b1;
        @(posedge clk); #1;
        take_n = 1'b0;
        m_mem[m_a] = w; m_a = m_a + 8'd1; m_err = 1'b1;
        @(negedge clk);
        chk("drop_error", {31'h0, mon_error}, 32'h1);
        chk("drop_ready", {31'h0, mon_ready}, 32'h1);
        chk("drop_monareg", {24'h0, dut.mon_a_q}, {24'h0, m_a});
        chk("drop_mondreg", mon_d, m_d);
        dbg(0, j_a(1'b1, 1'b0, 8'h11));
        chk("err_cleared", {31'h0, mon_error}, 32'h0);

        // CPU read coincident with a debug write to the same word
        w = $urandom;
        avs_address = 8'h11; avs_read = 1'b1; jdo = j_b(w); take_b = 1'b1;
        #1;
        cnt = 0;
        if (avs_waitrequest) cnt++;
        @(posedge clk); #1;
        take_b = 1'b0;
        m_mem[8'h11] = w; m_a = m_a + 8'd1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            cnt++;
        end
        chk("coll_wait_ge2", {31'h0, (cnt >= 2)}, 32'h1);
        chk("coll_wait_bounded", {31'h0, (cnt < 10)}, 32'h1);
        chk("coll_rdata", avs_readdata, w);
        @(posedge clk); #1;
        avs_read = 1'b0;
        @(negedge clk);
        chk("coll_monareg", {24'h0, dut.mon_a_q}, {24'h0, m_a});

        // Random mixed traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: dbg(0, j_a(1'($urandom_range(0, 1)), 1'b1, 8'($urandom)));
                1: dbg(0, j_a(1'($urandom_range(0, 1)), 1'b0, 8'($urandom)));
                2: dbg(1, j_b($urandom));
                3: dbg(2, 38'h0);
                4: cpu_wr(8'($urandom), $urandom);
                default: cpu_rd(8'($urandom));
            endcase
        end

        // Reset while a debug read is in flight
        jdo = j_a(1'b0, 1'b1, 8'h05); take_a = 1'b1;
        @(posedge clk); #1;
        take_a = 1'b0;
        reset_n = 1'b0;
        #1;
        m_a = 8'h00; m_d = 32'h0; m_err = 1'b0;
        chk("mid_rst_mondreg", mon_d, 32'h0);
        chk("mid_rst_ready", {31'h0, mon_ready}, 32'h1);
        chk("mid_rst_monareg", {24'h0, dut.mon_a_q}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_monareg", {24'h0, dut.mon_a_q}, 32'h0);
        cpu_rd(8'h05); cpu_rd(8'h10); cpu_rd(8'h11); cpu_rd(8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sopc_compteur_cpu_debug_mon_ram.md
SOPC_COMPTEUR_CPU_DEBUG_MON_RAM -- requirements
Module: sopc_compteur_cpu_debug_mon_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width (RAM depth 2**ADDR_W x 32).
REQ-002 SHALL have port clk, input, 1, single system clock; all logic rises on clk.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port jdo, input, 38, debug command word from the JTAG debug slave.
REQ-005 SHALL have port take_action_ocimem_a, input, 1, one-cycle pulse: load address / optional read.
REQ-006 SHALL have port take_action_ocimem_b, input, 1, one-cycle pulse: write jdo[34:3] at current address.
REQ-007 SHALL have port take_no_action_ocimem_a, input, 1, one-cycle pulse: read at current address (streaming read).
REQ-008 SHALL have port MonDReg, output, 32, last debug read data.
REQ-009 SHALL have port monitor_ready, output, 1, debug engine idle/result valid.
REQ-010 SHALL have port monitor_error, output, 1, sticky: debug action dropped while busy.
REQ-011 SHALL have ports avs_address (in, ADDR_W), avs_read (in, 1), avs_write (in, 1), avs_writedata (in, 32): CPU-side Avalon-MM slave request.
REQ-012 SHALL have ports avs_readdata (out, 32), avs_waitrequest (out, 1): CPU-side response.

Function
REQ-013 SHALL implement states IDLE, DBG_RD, DBG_WR, CPU_RD; only IDLE accepts new requests.
REQ-014 In IDLE, a debug pulse SHALL win over a simultaneous CPU request; CPU request stays stalled (avs_waitrequest=1).
REQ-015 take_action_ocimem_a: MonAReg <= jdo[33:26]; if jdo[35]=1 clear monitor_error; if jdo[34]=1 issue RAM read at jdo[33:26] -> DBG_RD, else -> DBG_WR-equivalent 1-cycle completion (no RAM write).
REQ-016 take_no_action_ocimem_a: RAM read at MonAReg -> DBG_RD.
REQ-017 DBG_RD (1 cycle): MonDReg <= RAM q; MonAReg <= MonAReg+1; -> IDLE. Read result visible 2 cycles after pulse.
REQ-018 take_action_ocimem_b: RAM[MonAReg] <= jdo[34:3] in accept cycle -> DBG_WR (1 cycle): MonAReg <= MonAReg+1; -> IDLE.
REQ-019 monitor_ready SHALL register 0 the cycle after any accepted debug pulse and 1 the cycle after return to IDLE (low exactly 1 cycle per op).
REQ-020 Debug pulse arriving when state != IDLE SHALL be dropped and set monitor_error <= 1 (sticky until cleared per REQ-015).
REQ-021 MonAReg SHALL wrap modulo 2**ADDR_W (255 -> 0).
REQ-022 CPU write in IDLE with no debug pulse: RAM[avs_address] <= avs_writedata, avs_waitrequest=0 same cycle.
REQ-023 CPU read in IDLE with no debug pulse: issue RAM read -> CPU_RD (avs_waitrequest=1); CPU_RD: avs_readdata=RAM q, avs_waitrequest=0, -> IDLE.
REQ-024 avs_waitrequest SHALL be 1 in all other cycles where avs_read or avs_write is high; avs_read and avs_write both high SHALL be treated as write.

Reset
REQ-025 On reset_n low: state=IDLE, MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0; RAM contents not cleared.
REQ-026 Reset mid-operation SHALL abandon the op without RAM write or address increment after assertion.

Structure
REQ-027 Package sopc_compteur_cpu_debug_pkg SHALL hold the state enum, ADDR_W default and jdo field positions (35 clr_err, 34 rd_after_load, 33:26 addr, 34:3 wdata).
REQ-028 Single sub-module sopc_compteur_cpu_debug_mon_ram_sp: single-port 2**ADDR_W x 32 RAM, 1-cycle registered read.

Verification
REQ-029 take_action_ocimem_a jdo[33:26]=0x10, jdo[34]=0; three take_action_ocimem_b with data 0x11111111/0x22222222/0x33333333 -> RAM[0x10..0x12] hold those values, MonAReg=0x13.
REQ-030 ocimem_a addr=0x10, jdo[34]=1 -> MonDReg=0x11111111 two cycles later, monitor_ready low 1 cycle; then take_no_action_ocimem_a -> MonDReg=0x22222222.
REQ-031 Address 0xFF write then read via stream -> MonAReg wraps to 0x00.
REQ-032 Debug pulse one cycle after another -> second dropped, monitor_error=1; ocimem_a with jdo[35]=1 -> monitor_error=0.
REQ-033 CPU read of 0x11 coincident with ocimem_b -> debug write first, CPU avs_readdata returns new value, waitrequest high >=2 cycles.
REQ-034 reset_n low during DBG_RD -> MonDReg=0, monitor_ready=1, MonAReg=0 immediately; RAM contents preserved.
